// File: rtl/llm_cmd_arb_pkg.sv
// Shared widths and the command record for the command arbiter.
// The command record is the payload held in the arbiter's output register.
package llm_cmd_arb_pkg;

  localparam int CHI_ADDR_WIDTH = 32;
  localparam int CHI_DATA_WIDTH = 64;
  localparam int PRIORITY_WIDTH = 2;
  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_AGE_MAX    = 15;

  typedef struct packed {
    logic [CHI_ADDR_WIDTH-1:0] addr;
    logic [CHI_DATA_WIDTH-1:0] data;
    logic [7:0]                size;
    logic [3:0]                typ;
    logic                      snp;
    logic [31:0]               pld;
    logic [PRIORITY_WIDTH-1:0] prio;
  } arb_cmd_t;

endpackage

// File: rtl/llm_cmd_arb_if.sv
// Requester-side and command-side bundle of the arbiter.
// The master side drives requests and cmd_ready; the slave side is the arbiter.
interface llm_cmd_arb_if
  import llm_cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*CHI_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*CHI_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*8-1:0]              req_size;
  logic [NUM_REQ*4-1:0]              req_type;
  logic [NUM_REQ-1:0]                req_snp;
  logic [NUM_REQ*32-1:0]             req_pld;
  logic [NUM_REQ*PRIORITY_WIDTH-1:0] req_priority;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [CHI_ADDR_WIDTH-1:0] cmd_addr;
  logic [CHI_DATA_WIDTH-1:0] cmd_data;
  logic [7:0]                cmd_size;
  logic [3:0]                cmd_type;
  logic                      cmd_snp;
  logic [31:0]               cmd_pld;
  logic [PRIORITY_WIDTH-1:0] cmd_priority;
  logic [SRC_W-1:0]          cmd_src;
  logic [15:0]               urgent_grant_cnt;

  modport master (
    output req_valid, req_addr, req_data, req_size, req_type, req_snp, req_pld,
           req_priority, cmd_ready,
    input  req_ready, cmd_valid, cmd_addr, cmd_data, cmd_size, cmd_type, cmd_snp,
           cmd_pld, cmd_priority, cmd_src, urgent_grant_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, req_type, req_snp, req_pld,
           req_priority, cmd_ready,
    output req_ready, cmd_valid, cmd_addr, cmd_data, cmd_size, cmd_type, cmd_snp,
           cmd_pld, cmd_priority, cmd_src, urgent_grant_cnt
  );

endinterface

// File: rtl/llm_cmd_arb_rr_pick.sv
// Combinational rotating-priority picker: first set candidate at or after i_ptr,
// scanning circularly, returned as one-hot grant plus index.
module llm_cmd_arb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_cand,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W:0] w_j;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_any   = |i_cand;
    w_j     = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, i_ptr} + (IDX_W+1)'(k);
      // explicit wrap keeps non-power-of-2 N inside 0..N-1
      if (w_j >= (IDX_W+1)'(N)) w_j = w_j - (IDX_W+1)'(N);
      if (!w_found && i_cand[w_j[IDX_W-1:0]]) begin
        w_found              = 1'b1;
        o_gnt[w_j[IDX_W-1:0]] = 1'b1;
        o_idx                = w_j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/llm_cmd_arb.sv
// Priority arbiter with round-robin tie-break and age-based anti-starvation,
// feeding one registered command stage toward llm_cmd_ctrl.
module llm_cmd_arb
  import llm_cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int AGE_MAX = ARB_AGE_MAX
) (
  input logic          clk,
  input logic          rst_n,
  llm_cmd_arb_if.slave arb
);

  localparam int AGE_WIDTH = $clog2(AGE_MAX + 1);
  localparam int SRC_W     = $clog2(NUM_REQ);
  localparam logic [AGE_WIDTH-1:0]      AGE_LIM = AGE_WIDTH'(AGE_MAX);
  localparam logic [PRIORITY_WIDTH-1:0] PRI_TOP = '1;

  function automatic logic [AGE_WIDTH-1:0] age_sat_inc(input logic [AGE_WIDTH-1:0] a);
    return (a == AGE_LIM) ? a : a + 1'b1;
  endfunction

  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [SRC_W-1:0] ptr_next(input logic [SRC_W-1:0] w);
    return (w == SRC_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  logic [AGE_WIDTH-1:0]      r_age [NUM_REQ];
  logic [SRC_W-1:0]          r_rr_ptr;
  logic [SRC_W-1:0]          r_src_p0;
  logic                      r_cmd_vld_p0;
  arb_cmd_t                  r_cmd_p0;
  logic [15:0]               r_ugc;

  logic [NUM_REQ-1:0]        w_urgent;
  logic [NUM_REQ-1:0]        w_cand;
  logic [NUM_REQ-1:0]        w_gnt;
  logic [PRIORITY_WIDTH-1:0] w_eff_pri [NUM_REQ];
  logic [PRIORITY_WIDTH-1:0] w_max_pri;
  logic [SRC_W-1:0]          w_idx;
  logic                      w_any;
  logic                      w_load_en;
  logic                      w_accept;
  arb_cmd_t                  w_sel;

  // urgent requesters jump to the top priority level; candidates share the maximum
  always_comb begin
    w_urgent  = '0;
    w_cand    = '0;
    w_max_pri = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_urgent[i]  = (r_age[i] == AGE_LIM);
      w_eff_pri[i] = w_urgent[i] ? PRI_TOP
                                 : arb.req_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
      if (arb.req_valid[i] && (w_eff_pri[i] > w_max_pri)) w_max_pri = w_eff_pri[i];
    end
    for (int i = 0; i < NUM_REQ; i++)
      w_cand[i] = arb.req_valid[i] && (w_eff_pri[i] == w_max_pri);
  end

  llm_cmd_arb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .i_cand (w_cand),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_load_en     = !r_cmd_vld_p0 || arb.cmd_ready;
  assign w_accept      = rst_n && w_load_en && w_any;
  assign arb.req_ready = w_accept ? w_gnt : '0;

  always_comb begin
    w_sel      = '0;
    w_sel.addr = arb.req_addr[w_idx*CHI_ADDR_WIDTH +: CHI_ADDR_WIDTH];
    w_sel.data = arb.req_data[w_idx*CHI_DATA_WIDTH +: CHI_DATA_WIDTH];
    w_sel.size = arb.req_size[w_idx*8 +: 8];
    w_sel.typ  = arb.req_type[w_idx*4 +: 4];
    w_sel.snp  = arb.req_snp[w_idx];
    w_sel.pld  = arb.req_pld[w_idx*32 +: 32];
    w_sel.prio = arb.req_priority[w_idx*PRIORITY_WIDTH +: PRIORITY_WIDTH];
  end

  // ---- stage p0: output command register, arbitration state, ages ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_vld_p0 <= 1'b0;
      r_cmd_p0     <= '0;
      r_src_p0     <= '0;
      r_rr_ptr     <= '0;
      r_ugc        <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_age[i] <= '0;
    end else begin
      if (w_accept) begin
        r_cmd_vld_p0 <= 1'b1;
        r_cmd_p0     <= w_sel;
        r_src_p0     <= w_idx;
        r_rr_ptr     <= ptr_next(w_idx);
        if (w_urgent[w_idx]) r_ugc <= cnt_sat_inc(r_ugc);
      end else if (arb.cmd_ready) begin
        r_cmd_vld_p0 <= 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!arb.req_valid[i] || (w_accept && w_gnt[i])) r_age[i] <= '0;
        else                                              r_age[i] <= age_sat_inc(r_age[i]);
      end
    end
  end

  assign arb.cmd_valid        = r_cmd_vld_p0;
  assign arb.cmd_addr         = r_cmd_p0.addr;
  assign arb.cmd_data         = r_cmd_p0.data;
  assign arb.cmd_size         = r_cmd_p0.size;
  assign arb.cmd_type         = r_cmd_p0.typ;
  assign arb.cmd_snp          = r_cmd_p0.snp;
  assign arb.cmd_pld          = r_cmd_p0.pld;
  assign arb.cmd_priority     = r_cmd_p0.prio;
  assign arb.cmd_src          = r_src_p0;
  assign arb.urgent_grant_cnt = r_ugc;

endmodule

// File: tb/tb_llm_cmd_arb.sv
// Bench for llm_cmd_arb: directed scenarios plus sticky random traffic,
// all checked each cycle against a queue-free reference model of the arbitration rules.
module tb_llm_cmd_arb;
  import llm_cmd_arb_pkg::*;

  localparam int N       = 4;
  localparam int AGE_MAX = 8;
  localparam int PW      = PRIORITY_WIDTH;
  localparam int CW      = CHI_ADDR_WIDTH + CHI_DATA_WIDTH + 8 + 4 + 1 + 32 + PW;
  localparam int KW      = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  llm_cmd_arb_if #(.NUM_REQ(N)) bus ();

  llm_cmd_arb #(
    .NUM_REQ (N),
    .AGE_MAX (AGE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  logic [N-1:0]              v;
  logic [CHI_ADDR_WIDTH-1:0] a  [N];
  logic [CHI_DATA_WIDTH-1:0] d  [N];
  logic [7:0]                sz [N];
  logic [3:0]                ty [N];
  logic                      sn [N];
  logic [31:0]               pl [N];
  logic [PW-1:0]             pr [N];
  logic                      crdy;
  logic [N-1:0]              obs_rdy;

  int n_cmp = 0;
  int n_err = 0;

  bit            m_vld;
  int            m_src, m_rr, m_ugc;
  int            m_age [N];
  logic [CW-1:0] m_cmd;

  task automatic chk(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] slice_cmd(input int i);
    return {a[i], d[i], sz[i], ty[i], sn[i], pl[i], pr[i]};
  endfunction

  function automatic int eff(input int i);
    return (m_age[i] == AGE_MAX) ? (1 << PW) - 1 : int'(pr[i]);
  endfunction

  // highest effective priority wins; ties go to the first one found from the rr pointer
  function automatic int pick();
    int best, w, j;
    best = -1;
    w    = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && eff(i) > best) best = eff(i);
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (w < 0 && v[j] && eff(j) == best) w = j;
    end
    return w;
  endfunction

  task automatic reset_model();
    m_vld = 0; m_src = 0; m_rr = 0; m_ugc = 0; m_cmd = '0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic drive();
    bus.req_valid = v;
    bus.cmd_ready = crdy;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*CHI_ADDR_WIDTH +: CHI_ADDR_WIDTH] = a[i];
      bus.req_data[i*CHI_DATA_WIDTH +: CHI_DATA_WIDTH] = d[i];
      bus.req_size[i*8 +: 8]                           = sz[i];
      bus.req_type[i*4 +: 4]                           = ty[i];
      bus.req_snp[i]                                   = sn[i];
      bus.req_pld[i*32 +: 32]                          = pl[i];
      bus.req_priority[i*PW +: PW]                     = pr[i];
    end
  endtask

  task automatic rnd_fields(input int i);
    a[i]  = $urandom;
    d[i]  = {$urandom, $urandom};
    sz[i] = 8'($urandom);
    ty[i] = 4'($urandom);
    sn[i] = 1'($urandom);
    pl[i] = $urandom;
    pr[i] = PW'($urandom);
  endtask

  // one clock: drive after negedge, check mid-cycle, advance the model, move to next negedge
  task automatic cycle();
    int w;
    bit acc;
    logic [N-1:0] er;
    drive();
    #1;
    w   = pick();
    acc = rst_n && (!m_vld || crdy) && (w >= 0);
    er  = '0;
    if (acc) er[w] = 1'b1;
    obs_rdy = bus.req_ready;
    chk("req_ready",  KW'(obs_rdy), KW'(er));
    chk("cmd_valid",  KW'(bus.cmd_valid), KW'(m_vld));
    chk("cmd_fields", KW'({bus.cmd_addr, bus.cmd_data, bus.cmd_size, bus.cmd_type,
                           bus.cmd_snp, bus.cmd_pld, bus.cmd_priority}), KW'(m_cmd));
    chk("cmd_src",    KW'(bus.cmd_src), KW'(m_src));
    chk("urgent_cnt", KW'(bus.urgent_grant_cnt), KW'(m_ugc));
    chk("rr_ptr",     KW'(dut.r_rr_ptr), KW'(m_rr));
    for (int i = 0; i < N; i++) chk("age", KW'(dut.r_age[i]), KW'(m_age[i]));
    if (!rst_n) begin
      reset_model();
    end else begin
      if (acc) begin
        if (m_age[w] == AGE_MAX && m_ugc < 65535) m_ugc++;
        m_vld = 1; m_cmd = slice_cmd(w); m_src = w; m_rr = (w + 1) % N;
      end else if (crdy) begin
        m_vld = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!v[i] || (acc && i == w)) m_age[i] = 0;
        else if (m_age[i] < AGE_MAX)  m_age[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    v = '0; crdy = 1'b0; obs_rdy = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0; d[i] = '0; sz[i] = '0; ty[i] = '0; sn[i] = 1'b0; pl[i] = '0; pr[i] = '0;
    end
    reset_model();
    drive();
    @(negedge clk);

    // reset held with all requesters valid
    v = 4'hF;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("rst_vld", KW'(bus.cmd_valid), KW'(0));
      chk("rst_rdy", KW'(obs_rdy), KW'(0));
      chk("rst_ugc", KW'(bus.urgent_grant_cnt), KW'(0));
    end
    rst_n = 1'b1;

    // priority selection
    for (int i = 0; i < N; i++) rnd_fields(i);
    v = 4'b0101; crdy = 1'b1;
    pr[0] = 2'd1; a[0] = 32'h100;
    pr[2] = 2'd3; a[2] = 32'h300;
    cycle();
    chk("pri_rdy0", KW'(obs_rdy), KW'(4'b0100));
    chk("pri_addr", KW'(bus.cmd_addr), KW'(32'h300));
    chk("pri_src2", KW'(bus.cmd_src), KW'(2));
    v = 4'b0001;
    cycle();
    chk("pri_rdy1", KW'(obs_rdy), KW'(4'b0001));
    chk("pri_src0", KW'(bus.cmd_src), KW'(0));
    v = '0;
    cycle();

    // round robin at equal priority
    do_reset();
    for (int i = 0; i < N; i++) begin rnd_fields(i); pr[i] = 2'd1; end
    v = 4'hF; crdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_seq", KW'(bus.cmd_src), KW'(k % N));
    end

    // backpressure while requester 1's command is held
    do_reset();
    v = 4'b0010; crdy = 1'b1;
    cycle();
    v = 4'b1101; crdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_src",  KW'(bus.cmd_src), KW'(1));
      chk("bp_rdy",  KW'(obs_rdy), KW'(0));
    end
    chk("bp_age0", KW'(dut.r_age[0]), KW'(5));
    chk("bp_age3", KW'(dut.r_age[3]), KW'(5));
    crdy = 1'b1;
    cycle();
    chk("bp_regrant", KW'(obs_rdy), KW'(4'b0100));

    // starvation relief through aging
    do_reset();
    v = 4'b0011; crdy = 1'b1; pr[0] = 2'd3; pr[1] = 2'd0;
    for (int k = 0; k <= AGE_MAX; k++) begin
      cycle();
      chk("starve_rdy", KW'(obs_rdy), (k == AGE_MAX) ? KW'(4'b0010) : KW'(4'b0001));
    end
    chk("starve_ugc", KW'(bus.urgent_grant_cnt), KW'(1));
    v = '0;
    cycle();

    // reset while a command is stalled in the output register
    do_reset();
    for (int i = 0; i < N; i++) pr[i] = 2'd1;
    v = 4'hF; crdy = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_vld", KW'(bus.cmd_valid), KW'(0));
    chk("mid_rst_ptr", KW'(dut.r_rr_ptr), KW'(0));
    crdy = 1'b1;
    cycle();
    chk("mid_rst_win", KW'(obs_rdy), KW'(4'b0001));

    // sticky random traffic: pending requests mostly persist so ages can saturate
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !obs_rdy[i] && $urandom_range(9) != 0)) begin
          v[i] = ($urandom_range(9) < 6);
          rnd_fields(i);
        end
      end
      crdy  = ($urandom_range(9) < 7);
      rst_n = ($urandom_range(299) != 0);
      cycle();
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
